// File: rtl/m16_sat_sub_acc.sv
// Signed saturating subtract-accumulator: loads init_val, then subtracts len streamed operands, clamping every step.
// Latency: in_ready one cycle after start; out_valid one cycle after the last accepted beat (or after start when len==0).
// Backpressure: operands accepted only in RUN; result/out_valid hold in DONE until out_ready.
module m16_sat_sub_acc #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] init_val,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             sat_flag,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] step_val;
    logic             step_sat;
    logic             beat;

    // in_ready is a pure decode of state, so a beat is simply in_valid while in RUN
    assign beat = (state_q == RUN) && in_valid;
    assign diff = {acc_q[WIDTH-1], acc_q} - {in_data[WIDTH-1], in_data};

    always_comb begin
        step_sat = (diff[WIDTH] != diff[WIDTH-1]);
        step_val = diff[WIDTH-1:0];
        if (step_sat) begin
            step_val = diff[WIDTH] ? MAX_NEG : MAX_POS;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = init_val;
                    cnt_d = len;
                    sat_d = 1'b0;
                    if (len == '0) begin
                        res_d   = init_val;
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (beat) begin
                    acc_d = step_val;
                    cnt_d = cnt_q - 1'b1;
                    sat_d = sat_q | step_sat;
                    if (cnt_q == CNT_W'(1)) begin
                        res_d   = step_val;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            res_q   <= res_d;
        end
    end

    assign in_ready  = (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = res_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_m16_sat_sub_acc.sv
// Bench for m16_sat_sub_acc: directed and random operations checked against a clamped-integer reference model.
module tb_m16_sat_sub_acc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] init_val = '0;
    logic [7:0]  len = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] result;
    logic        sat_flag;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [16:0] exp_q[$];   // {sat_flag, result}
    logic [16:0] mon_e;
    logic [15:0] ops[0:255];

    always #5 clk = ~clk;

    m16_sat_sub_acc #(.WIDTH(16), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .init_val  (init_val),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .sat_flag  (sat_flag),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Plain integer arithmetic clamped to the signed 16-bit range after each subtraction
    function automatic logic [16:0] model(input logic [15:0] init, input int n);
        int acc;
        int s;
        acc = $signed(init);
        s   = 0;
        for (int i = 0; i < n; i++) begin
            acc = acc - int'($signed(ops[i]));
            if (acc > 32767) begin
                acc = 32767;
                s   = 1;
            end else if (acc < -32768) begin
                acc = -32768;
                s   = 1;
            end
        end
        return {s[0], acc[15:0]};
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %0h expected no transfer", result);
            end else begin
                mon_e = exp_q.pop_front();
                chk("result", {16'd0, result}, {16'd0, mon_e[15:0]});
                chk("sat_flag", {31'd0, sat_flag}, {31'd0, mon_e[16]});
            end
        end
    end

    task automatic do_op(input logic [15:0] init, input int n, input int gap_pct,
                         input int hold, input bit poke_start);
        int budget;
        logic [16:0] e;
        budget = 0;
        while ((busy || out_valid) && budget < 100) begin
            @(posedge clk); #1;
            budget++;
        end
        chk("idle_before_start", {31'd0, busy}, 32'd0);
        e = model(init, n);
        exp_q.push_back(e);
        start = 1'b1; init_val = init; len = 8'(n);
        @(posedge clk); #1;
        start = 1'b0; init_val = 16'($urandom); len = 8'($urandom);
        if (n == 0) begin
            chk("len0_out_valid", {31'd0, out_valid}, 32'd1);
            chk("len0_in_ready", {31'd0, in_ready}, 32'd0);
        end else begin
            chk("in_ready_latency", {31'd0, in_ready}, 32'd1);
        end
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0; in_data = 16'($urandom); start = poke_start;
                @(posedge clk); #1;
                start = 1'b0;
                chk("gap_run_state", {30'd0, out_valid, in_ready}, 32'd1);
            end
            in_valid = 1'b1; in_data = ops[i];
            @(posedge clk); #1;
            in_valid = 1'b0; in_data = 16'($urandom);
        end
        chk("done_out_valid", {31'd0, out_valid}, 32'd1);
        chk("done_in_ready", {31'd0, in_ready}, 32'd0);
        for (int j = 0; j < hold; j++) begin
            start = poke_start;
            @(posedge clk); #1;
            chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_result", {16'd0, result}, {16'd0, e[15:0]});
        end
        start = poke_start; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; out_ready = 1'b0;
        chk("accept_out_valid", {31'd0, out_valid}, 32'd0);
        chk("accept_busy", {31'd0, busy}, 32'd0);
        chk("idle_result_hold", {16'd0, result}, {16'd0, e[15:0]});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        #3;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_result", {16'd0, result}, 32'd0);
        chk("rst_sat_flag", {31'd0, sat_flag}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        ops[0] = 16'd300; ops[1] = 16'd200;
        do_op(16'd1000, 2, 0, 0, 1'b0);

        ops[0] = 16'hFFFF;
        do_op(16'h7FFF, 1, 0, 0, 1'b0);

        ops[0] = 16'd1; ops[1] = 16'hFFFB;
        do_op(16'h8000, 2, 0, 0, 1'b0);

        // Abort mid-operation: outputs from the previous op are nonzero going in
        ops[0] = 16'd100; ops[1] = 16'd200; ops[2] = 16'd300;
        start = 1'b1; init_val = 16'd5; len = 8'd3;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1; in_data = ops[0];
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_result", {16'd0, result}, 32'd0);
        chk("abort_sat_flag", {31'd0, sat_flag}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        ops[0] = 16'd100; ops[1] = 16'd200; ops[2] = 16'd300;
        do_op(16'd5, 3, 0, 0, 1'b0);

        do_op(16'h1234, 0, 0, 2, 1'b1);

        ops[0] = 16'd7; ops[1] = 16'hFFF0; ops[2] = 16'd1000;
        do_op(16'hFF00, 3, 50, 5, 1'b1);

        for (int k = 0; k < 40; k++) begin
            int n;
            n = int'($urandom_range(0, 6));
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 5))
                    0:       ops[i] = 16'h7FFF;
                    1:       ops[i] = 16'h8000;
                    default: ops[i] = 16'($urandom);
                endcase
            end
            do_op(($urandom_range(0, 3) == 0) ? 16'h7FF0 : 16'($urandom), n, 25,
                  int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        @(posedge clk); #1;
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
